// File: rtl/register_file_param.sv
// Parameterised 2-read/1-write register file with registered reads and a sequenced clear FSM.
// Optional write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
module register_file_param #(
  parameter int W       = 16,
  parameter int AW      = 4,
  parameter int R0_ZERO = 0
) (
  input  logic          clk,
  input  logic          reset_asynchronous_n,
  input  logic          write_enable,
  input  logic [AW-1:0] inp_write_address0,
  input  logic [W-1:0]  inp_write_data,
  input  logic [AW-1:0] inp_read_address0,
  input  logic [AW-1:0] inp_read_address1,
  input  logic          clear_start,
  output logic [W-1:0]  out_read_data0,
  output logic [W-1:0]  out_read_data1,
  output logic          out_clear_busy,
  output logic          out_clear_done
);

  localparam int DEPTH = 2 ** AW;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]    state_reg, state_next;
  // One bit wider than the address so the index can reach DEPTH without wrapping.
  logic [AW:0]   clear_idx_reg, clear_idx_next;
  logic [W-1:0]  mem_reg [DEPTH];
  logic          wr_accept;
  logic          clearing;
  logic [AW-1:0] rd_addr [2];

  assign clearing  = (state_reg == ST_CLEAR);
  assign wr_accept = write_enable && (state_reg == ST_IDLE) &&
                     !((R0_ZERO != 0) && (inp_write_address0 == '0));

  always_comb begin
    state_next     = state_reg;
    clear_idx_next = clear_idx_reg;
    case (state_reg)
      ST_IDLE: begin
        if (clear_start) begin
          state_next     = ST_CLEAR;
          clear_idx_next = '0;
        end
      end
      ST_CLEAR: begin
        clear_idx_next = clear_idx_reg + 1'b1;
        if (clear_idx_reg == (AW+1)'(DEPTH - 1)) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_asynchronous_n) begin
    if (!reset_asynchronous_n) begin
      state_reg     <= ST_IDLE;
      clear_idx_reg <= '0;
    end else begin
      state_reg     <= state_next;
      clear_idx_reg <= clear_idx_next;
    end
  end

  // Register 0 is never written when R0_ZERO is set, so it holds its reset value of zero.
  always_ff @(posedge clk or negedge reset_asynchronous_n) begin
    if (!reset_asynchronous_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (clearing) begin
      mem_reg[clear_idx_reg[AW-1:0]] <= '0;
    end else if (wr_accept) begin
      mem_reg[inp_write_address0] <= inp_write_data;
    end
  end

  assign rd_addr[0] = inp_read_address0;
  assign rd_addr[1] = inp_read_address1;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic         fwd;
      logic [W-1:0] data_reg;
`ifdef REGFILE_BYPASS_EN
      assign fwd = wr_accept && (rd_addr[gi] == inp_write_address0);
`else
      assign fwd = 1'b0;
`endif
      always_ff @(posedge clk or negedge reset_asynchronous_n) begin
        if (!reset_asynchronous_n) begin
          data_reg <= '0;
        end else begin
          data_reg <= fwd ? inp_write_data : mem_reg[rd_addr[gi]];
        end
      end
    end
  endgenerate

  assign out_read_data0 = g_rd[0].data_reg;
  assign out_read_data1 = g_rd[1].data_reg;
  assign out_clear_busy = (state_reg == ST_CLEAR) || (state_reg == ST_DONE);
  assign out_clear_done = (state_reg == ST_DONE);

endmodule

// File: doc/register_file_param.md
REGISTER_FILE_PARAM -- requirements
Module: register_file_param

Interface
REQ-001 SHALL provide parameter W, default 16, data width in bits (W >= 1).
REQ-002 SHALL provide parameter AW, default 4, address width; DEPTH = 2**AW registers.
REQ-003 SHALL provide parameter R0_ZERO, default 0; when 1, register 0 reads as zero and ignores writes.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset_asynchronous_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port write_enable  input  1  write strobe.
REQ-007 SHALL have port inp_write_address0  input  AW  write address.
REQ-008 SHALL have port inp_write_data  input  W  write data.
REQ-009 SHALL have port inp_read_address0  input  AW  read port 0 address.
REQ-010 SHALL have port inp_read_address1  input  AW  read port 1 address.
REQ-011 SHALL have port clear_start  input  1  request a clear of all registers.
REQ-012 SHALL have port out_read_data0  output  W  read port 0 data, registered.
REQ-013 SHALL have port out_read_data1  output  W  read port 1 data, registered.
REQ-014 SHALL have port out_clear_busy  output  1  high while the clear sequence runs.
REQ-015 SHALL have port out_clear_done  output  1  one-cycle pulse when the clear sequence completes.

Function
REQ-016 SHALL write inp_write_data into register[inp_write_address0] at the clock edge when write_enable=1 and the FSM is IDLE.
REQ-017 SHALL register both read ports: out_read_dataN at edge k+1 reflects inp_read_addressN sampled at edge k (1-cycle latency); both ports update every cycle independently.
REQ-018 SHALL return the same data on both ports when both read addresses are equal.
REQ-019 SHALL implement the FSM IDLE -> CLEAR -> DONE -> IDLE.
REQ-020 In IDLE, clear_start=1 SHALL move the FSM to CLEAR with the clear index at 0.
REQ-021 In CLEAR, the block SHALL zero register[index] each cycle and increment index, then move to DONE after index DEPTH-1 (DEPTH cycles in CLEAR).
REQ-022 DONE SHALL last exactly one cycle, with out_clear_done=1, and then return to IDLE.
REQ-023 out_clear_busy SHALL be 1 exactly in the CLEAR and DONE states.
REQ-024 While busy, the block SHALL discard write_enable; reads SHALL still be served and return 0 for registers already cleared.
REQ-025 While busy, the block SHALL ignore clear_start; clear_start held high in the DONE cycle SHALL NOT restart the sequence until the FSM is in IDLE.
REQ-026 With R0_ZERO=1, a write to address 0 SHALL be dropped and reads of address 0 SHALL return 0.
REQ-027 The clear index SHALL be AW+1 bits wide so the terminal compare does not wrap.

Reset
REQ-028 Asserting reset_asynchronous_n low SHALL immediately clear all registers, out_read_data0/1, out_clear_busy and out_clear_done to 0 and put the FSM in IDLE, including mid-clear.
REQ-029 After reset is released, the first write SHALL be accepted at the first rising clock edge.

Configuration
REQ-030 With macro REGFILE_BYPASS_EN defined, a read address equal to the write address on an accepted write SHALL return inp_write_data at the next edge (write-through forwarding, port-independent, suppressed for address 0 when R0_ZERO=1).
REQ-031 With REGFILE_BYPASS_EN undefined, the same collision SHALL return the register's previous value; the new value SHALL be visible from the following read.

Verification
REQ-032 Reset, write 0xA5A5 to address 3, read address 3 on both ports -> 0xA5A5 on both one cycle after the address is presented.
REQ-033 Write 0x1234 to address 7 while reading address 7 in the same cycle (old value 0x0000) -> 0x1234 with the bypass macro, 0x0000 without it.
REQ-034 Fill all 16 registers with 0xFFFF, then pulse clear_start -> busy for 17 cycles, done pulses once, all reads 0; a write of 0x5555 attempted during CLEAR does not land.
REQ-035 R0_ZERO=1: write 0xBEEF to address 0 -> reads return 0x0000.
REQ-036 Assert reset for 1 cycle in the middle of CLEAR (index 5) -> busy=0 immediately, all registers 0, FSM in IDLE, a new clear_start is accepted.
REQ-037 W=32, AW=5: write 0xDEADBEEF to address 31 and read address 31 -> 0xDEADBEEF; the clear takes 32 CLEAR cycles.
